spike_delta_encoder: RTL and testbench

//  Send-on-delta spike encoder feeding the LIF neuron's spike_in. Accepts sensor samples over a

---
 rtl/snn_pkg.sv | 15 +
 rtl/spk_refract_timer.sv | 28 ++
 rtl/spike_delta_encoder.sv | 142 ++++++++++++++
 tb/tb_spike_delta_encoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared SNN definitions: encoder/neuron FSM states and default widths.
// Used by spike_delta_encoder and the LIF neuron.
package snn_pkg;

    localparam int SNN_DATA_W    = 12;
    localparam int SNN_REFRACT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        FIRE,
        GAP
    } snn_state_t;

endpackage

// File: rtl/spk_refract_timer.sv
// Refractory down-counter: load a value, decrement on request, done at zero.
// Shared between the delta encoder and the LIF neuron.
module spk_refract_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/spike_delta_encoder.sv
// Send-on-delta spike encoder with burst cap and refractory gap.
// Define SPIKE_ENC_BIPOLAR_EN to also emit spike_dn on downward crossings.
module spike_delta_encoder
    import snn_pkg::*;
#(
    parameter int DATA_W    = SNN_DATA_W,
    parameter int REFRACT_W = SNN_REFRACT_W,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic [DATA_W-1:0]    sample_data,
    input  logic [DATA_W-1:0]    delta_thresh,
    input  logic [REFRACT_W-1:0] refract,
    output logic                 spike_up,
    output logic                 spike_dn,
    output logic                 burst_sat,
    output logic [DATA_W-1:0]    baseline,
    output logic [CNT_W-1:0]     spike_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    snn_state_t           state;
    logic [DATA_W-1:0]    target;
    logic [DATA_W-1:0]    delta;
    logic [REFRACT_W-1:0] rgap;
    logic [BW-1:0]        burst;
    logic [BW-1:0]        burst_inc;
    logic signed [DATA_W:0] d_up;
    logic signed [DATA_W:0] d_dn;
    logic signed [DATA_W:0] d_step;
    logic                 up_hit;
    logic                 dn_hit;
    logic                 tmr_load;
    logic                 tmr_done;

    assign d_up   = $signed({1'b0, target}) - $signed({1'b0, baseline});
    assign d_dn   = $signed({1'b0, baseline}) - $signed({1'b0, target});
    assign d_step = $signed({1'b0, delta});
    assign up_hit = (d_up >= d_step);
    assign dn_hit = (d_dn >= d_step);
    assign burst_inc = burst + 1'b1;

    // Timer is only loaded on the FIRE->GAP path, where rgap is nonzero.
    assign tmr_load = (state == FIRE) && (burst != BURST_MAX) && (rgap != '0);

    spk_refract_timer #(
        .W(REFRACT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(rgap - 1'b1),
        .dec     (state == GAP),
        .done    (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sample_ready <= 1'b0;
            target       <= '0;
            delta        <= '0;
            rgap         <= '0;
            burst        <= '0;
            spike_up     <= 1'b0;
            spike_dn     <= 1'b0;
            burst_sat    <= 1'b0;
            baseline     <= '0;
            spike_cnt    <= '0;
        end else begin
            spike_up  <= 1'b0;
            spike_dn  <= 1'b0;
            burst_sat <= 1'b0;
            unique case (state)
                IDLE: begin
                    sample_ready <= 1'b1;
                    if (sample_valid && sample_ready) begin
                        target       <= sample_data;
                        delta        <= delta_thresh;
                        rgap         <= refract;
                        burst        <= '0;
                        sample_ready <= 1'b0;
                        state        <= EVAL;
                    end
                end
                EVAL: begin
                    if (delta == '0) begin
                        baseline     <= target;
                        sample_ready <= 1'b1;
                        state        <= IDLE;
                    end else if (up_hit) begin
                        spike_up  <= 1'b1;
                        baseline  <= baseline + delta;
                        spike_cnt <= spike_cnt + 1'b1;
                        burst     <= burst_inc;
                        burst_sat <= (burst_inc == BURST_MAX);
                        state     <= FIRE;
                    end else if (dn_hit) begin
`ifdef SPIKE_ENC_BIPOLAR_EN
                        spike_dn  <= 1'b1;
                        baseline  <= baseline - delta;
                        spike_cnt <= spike_cnt + 1'b1;
                        burst     <= burst_inc;
                        burst_sat <= (burst_inc == BURST_MAX);
                        state     <= FIRE;
`else
                        baseline     <= target;
                        sample_ready <= 1'b1;
                        state        <= IDLE;
`endif
                    end else begin
                        sample_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                FIRE: begin
                    if (burst == BURST_MAX) begin
                        baseline     <= target;
                        sample_ready <= 1'b1;
                        state        <= IDLE;
                    end else if (rgap == '0) begin
                        state <= EVAL;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tmr_done) begin
                        state <= EVAL;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_delta_encoder.sv
// Randomized scoreboard bench for spike_delta_encoder.
// Honours SPIKE_ENC_BIPOLAR_EN the same way as the design.
module tb_spike_delta_encoder;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [11:0] sample_data = '0;
    logic [11:0] delta_thresh = '0;
    logic [7:0]  refract = '0;
    logic        spike_up;
    logic        spike_dn;
    logic        burst_sat;
    logic [11:0] baseline;
    logic [15:0] spike_cnt;

    spike_delta_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_data (sample_data),
        .delta_thresh(delta_thresh),
        .refract     (refract),
        .spike_up    (spike_up),
        .spike_dn    (spike_dn),
        .burst_sat   (burst_sat),
        .baseline    (baseline),
        .spike_cnt   (spike_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int up;
        int dn;
        int sat;
        int cnt;
    } spk_t;

    typedef struct {
        int cyc;
        int base;
        int cnt;
    } rdy_t;

    spk_t spk_q[$];
    rdy_t rdy_q[$];

    int checks = 0;
    int errors = 0;
    int m_base = 0;
    int m_cnt = 0;
    bit mon_en = 0;
    bit prev_ready = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: walk the sample toward its target one delta at a time.
    task automatic model(input int h, input int data, input int dl, input int rf);
        int c;
        int n;
        bit done;
        rdy_t r;
        spk_t s;
        c = h;
        n = 0;
        done = 0;
        while (!done) begin
            if (dl == 0) begin
                m_base = data;
                r.cyc = c + 1;
                done = 1;
            end else if (data - m_base >= dl || m_base - data >= dl) begin
                s.up = (data > m_base);
                s.dn = !s.up;
`ifndef SPIKE_ENC_BIPOLAR_EN
                if (s.dn) begin
                    m_base = data;
                    r.cyc = c + 1;
                    done = 1;
                    continue;
                end
`endif
                n++;
                m_cnt = (m_cnt + 1) % 65536;
                m_base = s.up ? m_base + dl : m_base - dl;
                s.cyc = c + 1;
                s.sat = (n == MAXB);
                s.cnt = m_cnt;
                spk_q.push_back(s);
                if (s.sat) begin
                    m_base = data;
                    r.cyc = c + 2;
                    done = 1;
                end else begin
                    c = c + 2 + rf;
                end
            end else begin
                r.cyc = c + 1;
                done = 1;
            end
        end
        r.base = m_base;
        r.cnt = m_cnt;
        rdy_q.push_back(r);
    endtask

    task automatic send(input int data, input int dl, input int rf);
        int w;
        int h;
        sample_data = 12'(data);
        delta_thresh = 12'(dl);
        refract = 8'(rf);
        sample_valid = 1'b1;
        w = 0;
        while (!sample_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            chk("ready_timeout", 0, 1);
            sample_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        h = cyc;
        sample_valid = 1'b0;
        sample_data = 12'($urandom);
        delta_thresh = 12'($urandom);
        refract = 8'($urandom);
        model(h, data, dl, rf);
        @(negedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((spk_q.size() != 0 || rdy_q.size() != 0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_spk_q", spk_q.size(), 0);
        chk("drain_rdy_q", rdy_q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, int'(sample_ready), 0);
        chk({tag, "_up"}, int'(spike_up), 0);
        chk({tag, "_dn"}, int'(spike_dn), 0);
        chk({tag, "_sat"}, int'(burst_sat), 0);
        chk({tag, "_base"}, int'(baseline), 0);
        chk({tag, "_cnt"}, int'(spike_cnt), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (spike_up && spike_dn) chk("up_dn_overlap", 1, 0);
            if (spike_up || spike_dn || burst_sat) begin
                if (spk_q.size() == 0) begin
                    chk("unexpected_spike", 1, 0);
                end else begin
                    spk_t s;
                    s = spk_q.pop_front();
                    chk("spike_cyc", cyc, s.cyc);
                    chk("spike_up", int'(spike_up), s.up);
                    chk("spike_dn", int'(spike_dn), s.dn);
                    chk("burst_sat", int'(burst_sat), s.sat);
                    chk("spike_cnt", int'(spike_cnt), s.cnt);
                end
            end
            if (sample_ready && !prev_ready) begin
                if (rdy_q.size() == 0) begin
                    chk("unexpected_ready", 1, 0);
                end else begin
                    rdy_t r;
                    r = rdy_q.pop_front();
                    chk("ready_cyc", cyc, r.cyc);
                    chk("idle_base", int'(baseline), r.base);
                    chk("idle_cnt", int'(spike_cnt), r.cnt);
                end
            end
        end
        prev_ready <= sample_ready;
    end

    initial begin
        int dl;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        #1;
        chk("ready_at_release", int'(sample_ready), 0);
        @(negedge clk);
        chk("ready_after_release", int'(sample_ready), 1);
        @(posedge clk);
        mon_en = 1;
        @(negedge clk);

        send(350, 100, 0);
        send(50, 100, 0);
        send(777, 0, 0);
        send(250, 100, 3);
        send(4095, 10, 0);
        send(3000, 400, 2);
        send(3000, 50, 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: dl = 0;
                1: dl = $urandom_range(1, 20);
                default: dl = $urandom_range(21, 900);
            endcase
            send($urandom_range(0, 4095), dl, $urandom_range(0, 4));
        end
        drain();

        send(0, 0, 0);
        drain();
        send(250, 100, 3);
        repeat (2) @(negedge clk);
        mon_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        spk_q.delete();
        rdy_q.delete();
        m_base = 0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midrst", int'(sample_ready), 1);
        @(posedge clk);
        mon_en = 1;
        @(negedge clk);
        send(350, 100, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
